// File: rtl/mem_access_ctrl.sv
// Load/store access controller: turns one CPU memory request into a single-beat memory bus transaction.
// Optional build macro MEMCTRL_ALIGN_CHECK_EN faults misaligned halfword/word accesses without touching the bus.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  dS,
    input  logic        btX,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  wait_cnt, cnt_nx;
    logic        lat_write, lat_write_nx;
    logic [1:0]  lat_size, lat_size_nx;
    logic        lat_sext, lat_sext_nx;
    logic [1:0]  lat_off, lat_off_nx;
    logic        mem_req_nx, mem_we_nx, done_nx, fault_nx;
    logic [31:0] mem_addr_nx, mem_wdata_nx, rdata_nx;
    logic [3:0]  mem_be_nx;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b10:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            2'b10:   r = {4{data[7:0]}};
            2'b01:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sext,
                                                 input logic [1:0] off, input logic [31:0] data);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = data;
        res = data;
        case (size)
            2'b10: begin
                sh  = data >> {off, 3'b000};
                res = sext ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            end
            2'b01: begin
                sh  = data >> {off[1], 4'b0000};
                res = sext ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            end
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef MEMCTRL_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b10:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction
`endif

    // Stall covers the accepting IDLE cycle and every WAIT cycle, never RESP.
    assign stall = !rst && (((state == IDLE) && (memread || memwrite)) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            lat_write <= 1'b0;
            lat_size  <= 2'b00;
            lat_sext  <= 1'b0;
            lat_off   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= cnt_nx;
            lat_write <= lat_write_nx;
            lat_size  <= lat_size_nx;
            lat_sext  <= lat_sext_nx;
            lat_off   <= lat_off_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_be    <= mem_be_nx;
            mem_wdata <= mem_wdata_nx;
            rdata     <= rdata_nx;
            done      <= done_nx;
            fault     <= fault_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = wait_cnt;
        lat_write_nx = lat_write;
        lat_size_nx  = lat_size;
        lat_sext_nx  = lat_sext;
        lat_off_nx   = lat_off;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_be_nx    = mem_be;
        mem_wdata_nx = mem_wdata;
        rdata_nx     = 32'd0;
        done_nx      = 1'b0;
        fault_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (memread || memwrite) begin
                    lat_write_nx = memwrite;
                    lat_size_nx  = dS;
                    lat_sext_nx  = btX;
                    lat_off_nx   = addr[1:0];
`ifdef MEMCTRL_ALIGN_CHECK_EN
                    if (misaligned(dS, addr[1:0])) begin
                        state_nx = RESP;
                        done_nx  = 1'b1;
                        fault_nx = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_nx     = WAIT;
                        cnt_nx       = 8'd0;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = memwrite;
                        mem_addr_nx  = {addr[31:2], 2'b00};
                        mem_be_nx    = lane_mask(dS, addr[1:0]);
                        mem_wdata_nx = memwrite ? replicate(dS, wdata) : 32'd0;
                    end
                end
            end
            WAIT: begin
                // Bus fields stay frozen until the access ends, then clear together.
                if (mem_ack || (wait_cnt == WAIT_LAST)) begin
                    state_nx     = RESP;
                    done_nx      = 1'b1;
                    fault_nx     = !mem_ack;
                    rdata_nx     = (mem_ack && !lat_write) ?
                                   load_extract(lat_size, lat_sext, lat_off, mem_rdata) : 32'd0;
                    mem_req_nx   = 1'b0;
                    mem_we_nx    = 1'b0;
                    mem_addr_nx  = 32'd0;
                    mem_be_nx    = 4'd0;
                    mem_wdata_nx = 32'd0;
                    cnt_nx       = 8'd0;
                end else begin
                    cnt_nx = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a scoreboard of expected access results.
// Expectations follow MEMCTRL_ALIGN_CHECK_EN when it is defined for the build.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread, memwrite;
    logic [1:0]  dS;
    logic        btX;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done, fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          reqs;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .dS        (dS),
        .btX       (btX),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference lane model, written lane by lane from the byte address.
    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b10) begin
            case (a[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (sz == 2'b01) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [7:0]  b;
        logic [15:0] h;
        b = wd[7:0];
        h = wd[15:0];
        if (sz == 2'b10) return {b, b, b, b};
        if (sz == 2'b01) return {h, h};
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                               input logic [31:0] a, input logic [31:0] rd);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(a[1:0]);
        if (sz == 2'b10) begin
            b = rd[8*off +: 8];
            return (sx && b[7]) ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
        end
        if (sz == 2'b01) begin
            h = a[1] ? rd[31:16] : rd[15:0];
            return (sx && h[15]) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
        end
        return rd;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEMCTRL_ALIGN_CHECK_EN
        if (sz == 2'b01) return a[0];
        if (sz != 2'b10) return a[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    // ackAt is the 1-based WAIT cycle in which mem_ack is raised; 0 means never.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int ackAt, input logic hold);
        exp_t e, got;
        int   cyc, reqCnt;
        e.be    = model_be(sz, a);
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = wr ? model_wdata(sz, wd) : 32'd0;
        if (model_misaligned(sz, a)) begin
            e.lat = 1; e.reqs = 0; e.fault = 1'b1; e.rdata = 32'd0;
        end else if (ackAt >= 1 && ackAt <= TO) begin
            e.lat = ackAt + 1; e.reqs = ackAt; e.fault = 1'b0;
            e.rdata = wr ? 32'd0 : model_load(sz, sx, a, rd);
        end else begin
            e.lat = TO + 1; e.reqs = TO; e.fault = 1'b1; e.rdata = 32'd0;
        end
        sb.push_back(e);

        checkOutput("idle_req", 32'(mem_req), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        memread   = !wr;
        memwrite  = wr;
        dS        = sz;
        btX       = sx;
        addr      = a;
        wdata     = wd;
        mem_rdata = rd;
        #1;
        checkOutput("accept_stall", 32'(stall), 32'd1);

        cyc = 0;
        reqCnt = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                memread  = 1'b0;
                memwrite = 1'b0;
            end
            if (done) break;
            if (cyc > 40) begin
                checkOutput("wait_bound", 32'(done), 32'd1);
                break;
            end
            checkOutput("wait_stall", 32'(stall), 32'd1);
            if (mem_req) begin
                reqCnt++;
                checkOutput("bus_we", 32'(mem_we), 32'(e.we));
                checkOutput("bus_be", 32'(mem_be), 32'(e.be));
                checkOutput("bus_addr", mem_addr, e.addr);
                checkOutput("bus_wdata", mem_wdata, e.wdata);
                mem_ack = (reqCnt == ackAt);
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;

        if (done) begin
            got = sb.pop_front();
            checkOutput("resp_rdata", rdata, got.rdata);
            checkOutput("resp_fault", 32'(fault), 32'(got.fault));
            checkOutput("latency", 32'(cyc), 32'(got.lat));
            checkOutput("req_cycles", 32'(reqCnt), 32'(got.reqs));
            checkOutput("resp_stall", 32'(stall), 32'd0);
        end
        @(negedge clk);
        checkOutput("after_done", 32'(done), 32'd0);
        checkOutput("after_fault", 32'(fault), 32'd0);
        checkOutput("after_rdata", rdata, 32'd0);
        if (!hold) begin
            memread  = 1'b0;
            memwrite = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        memread = 1'b1; memwrite = 1'b0; dS = 2'b00; btX = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_be", 32'(mem_be), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        memread = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // lb with sign extension, ack in first WAIT cycle
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 1, 1'b0);
        // lhu, ack in third WAIT cycle
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 3, 1'b0);
        // sb with lane replication
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h1234_5678, 1, 1'b0);
        // lw with no ack runs into the timeout
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 0, 1'b0);
        // lh on an odd address
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_4001, 32'd0, 32'h7777_8001, 2, 1'b0);
        // request held through RESP is taken only in the following IDLE
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_6004, 32'd0, 32'h0102_0304, 1, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_6004, 32'd0, 32'h0506_0708, 2, 1'b0);
        // dS=11 behaves as word, ack on the last legal WAIT cycle
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_7008, 32'hDEAD_BEEF, 32'd0, TO, 1'b0);

        // mem_ack while idle must not produce a response
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("stray_ack_done", 32'(done), 32'd0);
        checkOutput("stray_ack_req", 32'(mem_req), 32'd0);

        // reset in the second WAIT cycle, then a late ack
        memread = 1'b1; memwrite = 1'b0; dS = 2'b00; addr = 32'h0000_8000;
        @(negedge clk);
        memread = 1'b0;
        checkOutput("abort_req_wait1", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_stall_rst", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_req", 32'(mem_req), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("late_ack_done", 32'(done), 32'd0);
        checkOutput("late_ack_req", 32'(mem_req), 32'd0);
        checkOutput("late_ack_rdata", rdata, 32'd0);
        checkOutput("late_ack_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 1)), 1'b0);
        end

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 memread, memwrite  input  1 each  access request from decode.
REQ-005 dS  input  2  size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-006 btX  input  1  load extension: 1 sign, 0 zero.
REQ-007 addr  input  32  byte address; wdata  input  32  store data (low bits used for sub-word).
REQ-008 stall  output  1  freeze CPU while access is pending.
REQ-009 rdata  output  32  extended load result; done  output  1  access complete; fault  output  1  access error.
REQ-010 mem_req, mem_we  output  1 each; mem_addr  output  32  word address with low two bits 00; mem_be  output  4; mem_wdata  output  32.
REQ-011 mem_rdata  input  32; mem_ack  input  1  one-cycle acknowledge.
REQ-012 Parameter TIMEOUT, default 16, maximum cycles in WAIT before fault; legal range 1..255.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with memread|memwrite=1, the block SHALL latch addr/wdata/dS/btX and the kind (write wins if both are 1), then go to WAIT next edge.
REQ-015 stall SHALL be combinational: 1 in IDLE while a request is present, 1 in WAIT, 0 in RESP.
REQ-016 In WAIT, mem_req SHALL be 1 and mem_we/mem_addr/mem_be/mem_wdata SHALL be held stable until mem_ack.
REQ-017 Byte lanes are little-endian: byte mem_be=0001<<addr[1:0]; half mem_be=0011<<{addr[1],0}; word mem_be=1111; the same mem_be SHALL be driven for reads.
REQ-018 Store data SHALL be replicated: byte to all four lanes, half to both halves, word unchanged.
REQ-019 When mem_ack=1 in WAIT, the block SHALL capture the lane-selected load extended per btX, then go to RESP.
REQ-020 RESP SHALL last exactly one cycle with done=1; rdata is valid for loads and 0 for stores; the next state is IDLE.
REQ-021 A request present in RESP SHALL NOT be accepted; it is sampled in the following IDLE.
REQ-022 Minimum latency SHALL be request-to-done 2 cycles when mem_ack arrives in the first WAIT cycle.
REQ-023 A wait counter SHALL count WAIT cycles; when it reaches TIMEOUT with no ack, mem_req SHALL drop and RESP SHALL follow with fault=1 and rdata=0.
REQ-024 mem_ack outside WAIT SHALL be ignored.
REQ-025 rdata, done and fault SHALL hold their values only during RESP and be 0 otherwise.

Reset
REQ-026 With rst=1 at an edge, the state SHALL go to IDLE and the counter and all registered outputs SHALL clear to 0 (mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, done, fault).
REQ-027 stall SHALL be forced 0 while rst=1.
REQ-028 rst during WAIT SHALL abort the access: mem_req drops after that edge, and a late ack is ignored.

Configuration
REQ-029 When MEMCTRL_ALIGN_CHECK_EN is defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=00) SHALL skip WAIT, issue no mem_req, and go IDLE->RESP with fault=1 and rdata=0.
REQ-030 When MEMCTRL_ALIGN_CHECK_EN is undefined, misaligned low bits SHALL be ignored (half uses addr[1], word uses lane 0), and fault SHALL arise only from timeout.

Verification
REQ-031 lb addr=0x1003, btX=1, ack in 1st WAIT cycle, mem_rdata=0x80FFFFFF -> mem_be=1000, done at cycle 2, rdata=0xFFFFFF80.
REQ-032 lhu addr=0x2002, btX=0, mem_rdata=0xBEEF1234, ack after 3 WAIT cycles -> mem_be=1100, stall high for 4 cycles, rdata=0x0000BEEF.
REQ-033 sb addr=0x3001, wdata=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5, done=1, rdata=0.
REQ-034 lw with no ack, TIMEOUT=4 -> mem_req high 4 cycles then low, RESP fault=1, rdata=0.
REQ-035 rst in 2nd WAIT cycle, then ack the next cycle -> IDLE, no done, outputs 0.
REQ-036 lh addr=0x4001 with the macro defined -> no mem_req, fault=1 at cycle 1; without the macro -> mem_be=0011, normal completion.
